// File: rtl/fifo_arb_pkg.sv
// Shared constants for the write-port arbiter: state encoding, counter/index
// widths and the default requester geometry.
package fifo_arb_pkg;

  localparam int CNT_W    = 4;
  localparam int ID_W     = 3;
  localparam int SLOTS    = 1 << ID_W;
  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // Successor of a requester index with wrap at nreq-1 (compare-and-clear).
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int nreq);
    return (id == ID_W'(nreq - 1)) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first valid requester at or after rr_ptr,
// scanning upward and wrapping at NREQ-1.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  localparam int CW = ID_W + 1;

  logic [SLOTS-1:0] valid_ext;
  logic [CW-1:0]    cand;

  assign valid_ext = SLOTS'(req_valid);

  // One extra bit on the candidate keeps rr_ptr+i from overflowing before the modulo.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && valid_ext[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the FIFO write port among NREQ
// requesters, with a burst cap and an owner-idle timeout.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4,
  parameter int IDLE_TO   = 8
) (
  input  logic               w_clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               w_full,
  output logic               w_en,
  output logic [DW-1:0]      w_data,
  output logic [2:0]         gnt_id,
  output logic               busy
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_TO);

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] idle_cnt;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [SLOTS-1:0] valid_ext;
  logic [SLOTS-1:0] last_ext;
  logic [SLOTS-1:0] ready_ext;
  logic [DW-1:0]    data_arr [SLOTS];
  logic             own_valid;
  logic             own_last;
  logic             beat;
  logic             release_now;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  assign valid_ext = SLOTS'(req_valid);
  assign last_ext  = SLOTS'(req_last);

  always_comb begin
    for (int i = 0; i < SLOTS; i++) data_arr[i] = '0;
    for (int i = 0; i < NREQ; i++) data_arr[i] = req_data[i*DW +: DW];
  end

  // A full FIFO stalls the owner without counting toward either release condition.
  assign busy      = (state == XFER);
  assign own_valid = valid_ext[gnt_id];
  assign own_last  = last_ext[gnt_id];
  assign beat      = busy & own_valid & ~w_full;
  assign ready_ext = beat ? (SLOTS'(1) << gnt_id) : '0;
  assign req_ready = ready_ext[NREQ-1:0];
  assign w_en      = beat;
  assign w_data    = busy ? data_arr[gnt_id] : '0;

  assign release_now = busy &
      ((beat & (own_last | ((beat_cnt + CNT_W'(1)) == BURST_LIM))) |
       (~own_valid & ((idle_cnt + CNT_W'(1)) == IDLE_LIM)));

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_found) begin
        state    <= XFER;
        gnt_id   <= pick_idx;
        beat_cnt <= '0;
        idle_cnt <= '0;
      end
    end else begin
      if (beat) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        idle_cnt <= '0;
      end else if (!own_valid) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
      if (release_now) begin
        state  <= IDLE;
        rr_ptr <= next_ptr(gnt_id, NREQ);
      end
    end
  end

endmodule
